ldpc_delay_sched: RTL and testbench

LDPC_DELAY_SCHED -- requirements
Module: ldpc_delay_sched

---
 rtl/ldpc_delay_sched_if.sv | 64 ++++++
 rtl/ldpc_delay_sched.sv | 111 +++++++++++
 tb/tb_ldpc_delay_sched.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_delay_sched_if.sv
// Handshake bundle for ldpc_delay_sched: upstream, encoder, delay FIFO, parity and output streams.
// Signal names carry the direction as seen from the scheduler (slave modport).
interface ldpc_delay_sched_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] i_in_data;
    logic             i_in_valid;
    logic             o_in_ready;

    logic [WIDTH-1:0] o_enc_data;
    logic             o_enc_valid;
    logic             i_enc_ready;

    logic [WIDTH-1:0] o_fifo_wr_data;
    logic             o_fifo_wr_valid;
    logic             i_fifo_wr_ready;

    logic [WIDTH-1:0] i_fifo_rd_data;
    logic             i_fifo_rd_valid;
    logic             o_fifo_rd_ready;

    logic [WIDTH-1:0] i_par_data;
    logic             i_par_valid;
    logic             o_par_ready;

    logic [WIDTH-1:0] o_out_data;
    logic             o_out_valid;
    logic             i_out_ready;
    logic             o_out_last;

    logic             o_busy;

    modport slave (
        input  i_in_data, i_in_valid,
        output o_in_ready,
        output o_enc_data, o_enc_valid,
        input  i_enc_ready,
        output o_fifo_wr_data, o_fifo_wr_valid,
        input  i_fifo_wr_ready,
        input  i_fifo_rd_data, i_fifo_rd_valid,
        output o_fifo_rd_ready,
        input  i_par_data, i_par_valid,
        output o_par_ready,
        output o_out_data, o_out_valid, o_out_last,
        input  i_out_ready,
        output o_busy
    );

    modport master (
        output i_in_data, i_in_valid,
        input  o_in_ready,
        input  o_enc_data, o_enc_valid,
        output i_enc_ready,
        input  o_fifo_wr_data, o_fifo_wr_valid,
        output i_fifo_wr_ready,
        output i_fifo_rd_data, i_fifo_rd_valid,
        input  o_fifo_rd_ready,
        output i_par_data, i_par_valid,
        input  o_par_ready,
        input  o_out_data, o_out_valid, o_out_last,
        output i_out_ready,
        input  o_busy
    );
endinterface

// File: rtl/ldpc_delay_sched.sv
// Codeword scheduler: broadcasts systematic words to encoder and delay FIFO, then emits the
// delayed systematic words followed by the encoder parity, all as combinational pass-through.
module ldpc_delay_sched #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned K_WORDS = 1024,
    parameter int unsigned P_WORDS = 512
) (
    input  logic                i_clock,
    input  logic                i_reset,
    ldpc_delay_sched_if.slave   sched_io
);
    localparam int unsigned MaxWords = (K_WORDS > P_WORDS) ? K_WORDS : P_WORDS;
    localparam int unsigned CntW     = $clog2(MaxWords) + 1;
    localparam logic [CntW-1:0] KLast = CntW'(K_WORDS - 1);
    localparam logic [CntW-1:0] PLast = CntW'(P_WORDS - 1);

    typedef enum logic [1:0] {ST_INIT, ST_LOAD, ST_SYS, ST_PAR} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sink_rdy;
    logic [WIDTH-1:0] out_data;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sink_rdy = sched_io.i_enc_ready & sched_io.i_fifo_wr_ready;
        out_data = '0;

        sched_io.o_in_ready      = 1'b0;
        sched_io.o_enc_valid     = 1'b0;
        sched_io.o_fifo_wr_valid = 1'b0;
        sched_io.o_fifo_rd_ready = 1'b0;
        sched_io.o_par_ready     = 1'b0;
        sched_io.o_out_valid     = 1'b0;
        sched_io.o_out_last      = 1'b0;
        sched_io.o_busy          = 1'b0;

        // Outputs are gated by reset too so they drop before the flops settle.
        if (!i_reset) begin
            unique case (state_q)
                ST_INIT: begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
                ST_LOAD: begin
                    // Both sinks take the word together or neither sees it.
                    sched_io.o_in_ready      = sink_rdy;
                    sched_io.o_enc_valid     = sched_io.i_in_valid & sink_rdy;
                    sched_io.o_fifo_wr_valid = sched_io.i_in_valid & sink_rdy;
                    sched_io.o_busy          = (cnt_q != '0);
                    if (sched_io.i_in_valid && sink_rdy) begin
                        if (cnt_q == KLast) begin
                            state_d = ST_SYS;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_SYS: begin
                    out_data                 = sched_io.i_fifo_rd_data;
                    sched_io.o_out_valid     = sched_io.i_fifo_rd_valid;
                    sched_io.o_fifo_rd_ready = sched_io.i_out_ready;
                    sched_io.o_busy          = 1'b1;
                    if (sched_io.i_fifo_rd_valid && sched_io.i_out_ready) begin
                        if (cnt_q == KLast) begin
                            state_d = ST_PAR;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_PAR: begin
                    out_data             = sched_io.i_par_data;
                    sched_io.o_out_valid = sched_io.i_par_valid;
                    sched_io.o_par_ready = sched_io.i_out_ready;
                    sched_io.o_out_last  = (cnt_q == PLast);
                    sched_io.o_busy      = 1'b1;
                    if (sched_io.i_par_valid && sched_io.i_out_ready) begin
                        if (cnt_q == PLast) begin
                            state_d = ST_LOAD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign sched_io.o_enc_data     = sched_io.i_in_data;
    assign sched_io.o_fifo_wr_data = sched_io.i_in_data;
    assign sched_io.o_out_data     = out_data;
endmodule

// File: tb/tb_ldpc_delay_sched.sv
// Bench for ldpc_delay_sched (K=4, P=2): directed table, hand sequences and randomized traffic
// checked against a word-count model of the codeword schedule and an output scoreboard.
module tb_ldpc_delay_sched;
    localparam int unsigned W  = 8;
    localparam int unsigned K  = 4;
    localparam int unsigned P  = 2;
    localparam int unsigned CW = K + P;

    logic clk = 1'b0;
    bit   clk_run = 1'b1;
    logic rst;

    always #5 if (clk_run) clk = ~clk;

    ldpc_delay_sched_if #(.WIDTH(W)) sif ();

    ldpc_delay_sched #(
        .WIDTH  (W),
        .K_WORDS(K),
        .P_WORDS(P)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .sched_io(sif)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } out_t;

    typedef struct packed {
        logic       in_v, enc_r, wr_r, out_r, par_v, rd_v;
        logic [7:0] exp_ctl;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] in_q[$];
    logic [W-1:0] fq[$];
    logic [W-1:0] pq[$];
    out_t         exp_q[$];

    int mdl_l, mdl_e, mdl_cw, par_cw;
    bit mdl_init;
    bit rnd, out_tog, out_tog_v;
    int enc_block;
    bit prev_stall, prev_in_stall;
    logic [W-1:0] prev_data;
    int n_last, n_wr;
    vec_t tbl[8];

    function automatic logic [W-1:0] par_word(int cw, int j);
        return W'(cw * 16 + j) ^ 8'hC3;
    endfunction

    function automatic logic [7:0] act_ctl();
        return {sif.o_in_ready, sif.o_enc_valid, sif.o_fifo_wr_valid, sif.o_fifo_rd_ready,
                sif.o_par_ready, sif.o_out_valid, sif.o_out_last, sif.o_busy};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic set_inputs(input logic v);
        sif.i_in_valid      = v;
        sif.i_in_data       = '0;
        sif.i_enc_ready     = v;
        sif.i_fifo_wr_ready = v;
        sif.i_fifo_rd_valid = v;
        sif.i_fifo_rd_data  = '0;
        sif.i_par_valid     = v;
        sif.i_par_data      = '0;
        sif.i_out_ready     = v;
    endtask

    task automatic push_cw(input int n);
        for (int i = 0; i < n * int'(K); i++) in_q.push_back(W'($urandom));
    endtask

    // Entered and left on a falling edge; reset is raised mid low-phase.
    task automatic apply_reset();
        #2;
        set_inputs(1'b1);
        rst = 1'b1;
        #1;
        check("reset_outputs", act_ctl(), 8'h00);
        mdl_l = 0; mdl_e = 0; mdl_cw = 0; par_cw = 0;
        exp_q.delete(); fq.delete(); pq.delete();
        prev_stall = 1'b0; prev_in_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        mdl_init = 1'b1;
    endtask

    task automatic cycle();
        bit           in_phase, out_phase, src_v, in_x, out_x, blk;
        bit           wr_x, rd_x, par_x, last_x;
        logic [7:0]   exp_ctl;
        logic [W-1:0] wr_d, cur_in;
        out_t         e;

        if (pq.size() == 0) begin
            for (int j = 0; j < int'(P); j++) pq.push_back(par_word(par_cw, j));
            par_cw++;
        end

        blk = !mdl_init && enc_block > 0 && mdl_l == 1;
        if (blk) enc_block--;
        sif.i_in_valid = in_q.size() > 0 && (prev_in_stall || !rnd || $urandom_range(0, 3) != 0);
        sif.i_in_data  = in_q.size() > 0 ? in_q[0] : W'($urandom);
        sif.i_enc_ready     = !blk && (!rnd || $urandom_range(0, 4) != 0);
        sif.i_fifo_wr_ready = !rnd || $urandom_range(0, 4) != 0;
        sif.i_fifo_rd_valid = fq.size() > 0 && (prev_stall || !rnd || $urandom_range(0, 3) != 0);
        sif.i_fifo_rd_data  = fq.size() > 0 ? fq[0] : '0;
        sif.i_par_valid     = pq.size() > 0 && (prev_stall || !rnd || $urandom_range(0, 3) != 0);
        sif.i_par_data      = pq.size() > 0 ? pq[0] : '0;
        if (out_tog) begin
            sif.i_out_ready = out_tog_v;
            out_tog_v       = !out_tog_v;
        end else begin
            sif.i_out_ready = !rnd || $urandom_range(0, 3) != 0;
        end
        #1;

        // Phase follows from how many words of the codeword were loaded and emitted.
        in_phase  = !mdl_init && mdl_l < int'(K);
        out_phase = !mdl_init && mdl_l == int'(K);
        src_v     = (mdl_e < int'(K)) ? sif.i_fifo_rd_valid : sif.i_par_valid;
        exp_ctl[7] = in_phase && sif.i_enc_ready && sif.i_fifo_wr_ready;
        exp_ctl[6] = exp_ctl[7] && sif.i_in_valid;
        exp_ctl[5] = exp_ctl[6];
        exp_ctl[4] = out_phase && mdl_e < int'(K) && sif.i_out_ready;
        exp_ctl[3] = out_phase && mdl_e >= int'(K) && sif.i_out_ready;
        exp_ctl[2] = out_phase && src_v;
        exp_ctl[1] = out_phase && mdl_e == int'(CW) - 1;
        exp_ctl[0] = !mdl_init && (mdl_l > 0 || mdl_e > 0);
        check("ctl", act_ctl(), exp_ctl);
        if (exp_ctl[6])
            check("bcast_data", {sif.o_enc_data, sif.o_fifo_wr_data}, {2{sif.i_in_data}});
        if (prev_stall)
            check("stall_hold", {sif.o_out_valid, sif.o_out_data}, {1'b1, prev_data});
        if (sif.o_out_valid && sif.i_out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL out_extra: got word %0h, expected no output", sif.o_out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_word", {sif.o_out_data, sif.o_out_last}, {e.data, e.last});
            end
        end

        in_x   = exp_ctl[6];
        out_x  = exp_ctl[2] && sif.i_out_ready;
        wr_x   = sif.o_fifo_wr_valid && sif.i_fifo_wr_ready;
        wr_d   = sif.o_fifo_wr_data;
        rd_x   = sif.o_fifo_rd_ready && sif.i_fifo_rd_valid;
        par_x  = sif.o_par_ready && sif.i_par_valid;
        last_x = sif.o_out_valid && sif.i_out_ready && sif.o_out_last;
        cur_in = sif.i_in_data;
        prev_stall    = sif.o_out_valid && !sif.i_out_ready;
        prev_data     = sif.o_out_data;
        prev_in_stall = sif.i_in_valid && !sif.o_in_ready;

        @(posedge clk);
        if (wr_x) fq.push_back(wr_d);
        if (rd_x && fq.size() > 0) void'(fq.pop_front());
        if (par_x && pq.size() > 0) void'(pq.pop_front());
        if (wr_x) n_wr++;
        if (last_x) n_last++;

        if (mdl_init) begin
            mdl_init = 1'b0;
        end else begin
            if (in_x) begin
                exp_q.push_back('{data: cur_in, last: 1'b0});
                if (in_q.size() > 0) void'(in_q.pop_front());
                mdl_l++;
                if (mdl_l == int'(K))
                    for (int j = 0; j < int'(P); j++)
                        exp_q.push_back('{data: par_word(mdl_cw, j), last: (j == int'(P) - 1)});
            end
            if (out_x) begin
                mdl_e++;
                if (mdl_e == int'(CW)) begin
                    mdl_l = 0;
                    mdl_e = 0;
                    mdl_cw++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int i = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0 || mdl_l > 0) && i < budget) begin
            cycle();
            i++;
        end
        check(name, in_q.size() + exp_q.size() + mdl_l, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // {in_v, enc_r, wr_r, out_r, par_v, rd_v, {in_rdy,enc_v,wr_v,rd_rdy,par_rdy,out_v,last,busy}}
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_0000};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_0000};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'b0000_0000};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b1000_0000};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1110_0000};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'b1110_0000};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1000_0000};

        rst = 1'b1;
        set_inputs(1'b0);
        rnd = 1'b0; out_tog = 1'b0; out_tog_v = 1'b1; enc_block = 0;
        n_last = 0; n_wr = 0; mdl_init = 1'b0;
        apply_reset();
        cycle();

        // Combinational decode in LOAD with the clock parked low.
        clk_run = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sif.i_in_valid      = tbl[i].in_v;
            sif.i_enc_ready     = tbl[i].enc_r;
            sif.i_fifo_wr_ready = tbl[i].wr_r;
            sif.i_out_ready     = tbl[i].out_r;
            sif.i_par_valid     = tbl[i].par_v;
            sif.i_fifo_rd_valid = tbl[i].rd_v;
            sif.i_in_data       = W'(8'h30 + i);
            #1;
            check("table_ctl", act_ctl(), tbl[i].exp_ctl);
            if (tbl[i].exp_ctl[6])
                check("table_data", {sif.o_enc_data, sif.o_fifo_wr_data}, {2{sif.i_in_data}});
        end
        set_inputs(1'b0);
        clk_run = 1'b1;
        @(negedge clk);

        // All ready: S0..S3 then P0,P1 back to back, last on the 10th cycle.
        push_cw(1);
        c = 0;
        while (n_last == 0 && c < 40) begin
            cycle();
            c++;
        end
        check("cw_cycles", c, 10);
        check("cw_last", n_last, 1);

        // Encoder stalls during S1 while the FIFO is ready.
        enc_block = 2;
        n_wr = 0;
        push_cw(1);
        drain("enc_stall_drain", 60);
        check("fifo_writes", n_wr, K);
        check("enc_block_used", enc_block, 0);

        // Output ready toggling 1,0,1,0.
        out_tog = 1'b1; out_tog_v = 1'b1;
        push_cw(1);
        drain("toggle_drain", 60);
        out_tog = 1'b0;

        // Reset once S0..S2 have been emitted, then a fresh codeword.
        push_cw(1);
        c = 0;
        while (mdl_e < 3 && c < 40) begin
            cycle();
            c++;
        end
        check("pre_reset_emitted", mdl_e, 3);
        apply_reset();
        in_q.delete();
        cycle();
        push_cw(1);
        drain("post_reset_drain", 60);

        // Three back-to-back codewords.
        n_last = 0;
        push_cw(3);
        drain("b2b_drain", 120);
        check("b2b_last_count", n_last, 3);

        // Randomized traffic and stalls on every interface.
        rnd = 1'b1;
        n_last = 0;
        push_cw(20);
        drain("rand_drain", 4000);
        check("rand_last_count", n_last, 20);

        // Random reset in the middle of traffic.
        push_cw(5);
        c = 20 + int'($urandom_range(0, 40));
        for (int i = 0; i < c; i++) cycle();
        apply_reset();
        in_q.delete();
        cycle();
        n_last = 0;
        push_cw(3);
        drain("rand_reset_drain", 1000);
        check("rand_reset_last", n_last, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
